// File: rtl/pmt_lookup_if.sv
// Key-in / result-out stream bundle for the packet match table lookup engine.
// master = key producer and result consumer, slave = engine.
interface pmt_lookup_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int TAG_WIDTH  = 8
);
  logic                  key_valid;
  logic                  key_ready;
  logic [DATA_WIDTH-1:0] key_data;
  logic [TAG_WIDTH-1:0]  key_tag;
  logic                  res_valid;
  logic                  res_ready;
  logic                  res_hit;
  logic                  res_err;
  logic [ADDR_WIDTH-1:0] res_addr;
  logic [DATA_WIDTH-1:0] res_action;
  logic [TAG_WIDTH-1:0]  res_tag;

  modport master (
    output key_valid, key_data, key_tag, res_ready,
    input  key_ready, res_valid, res_hit, res_err,
    input  res_addr, res_action, res_tag
  );

  modport slave (
    input  key_valid, key_data, key_tag, res_ready,
    output key_ready, res_valid, res_hit, res_err,
    output res_addr, res_action, res_tag
  );
endinterface

// File: rtl/pmt_lookup_engine.sv
// One-at-a-time TCAM search + SRAM action fetch with
// miss/timeout defaulting and saturating hit/miss counters.
module pmt_lookup_engine #(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    ADDR_WIDTH     = 5,
  parameter int                    TAG_WIDTH      = 8,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_ACTION = '0,
  parameter int                    RD_TIMEOUT     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  pmt_lookup_if.slave           lk,
  output logic                  search_en,
  output logic [DATA_WIDTH-1:0] search_key,
  input  logic                  match_found,
  input  logic [ADDR_WIDTH-1:0] match_addr,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_valid,
  input  logic                  stats_clr,
  output logic [31:0]           hit_cnt,
  output logic [31:0]           miss_cnt
);
  localparam int CW = $clog2(RD_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, SRCH, MWAIT, RD, RWAIT, RESP
  } state_t;

  state_t                state, state_n;
  logic [TAG_WIDTH-1:0]  tag_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [CW-1:0]         tmo;
  logic                  tmo_done;
  logic                  enter_resp;
  logic                  hit_inc;
  logic                  miss_inc;

  assign tmo_done = (tmo == CW'(RD_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (lk.key_valid) state_n = SRCH;
      SRCH:    state_n = MWAIT;
      MWAIT:   state_n = match_found ? RD : RESP;
      RD:      state_n = RWAIT;
      RWAIT:   if (rd_valid || tmo_done) state_n = RESP;
      RESP:    if (lk.res_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    lk.key_ready = (state == IDLE) && !rst;
    lk.res_valid = (state == RESP) && !rst;
    enter_resp   = (state_n == RESP) && (state != RESP);
    hit_inc      = enter_resp && (state == RWAIT);
    miss_inc     = enter_resp && (state == MWAIT);
  end

  // Strobes are driven from the next state so they are true flops
  always_ff @(posedge clk) begin
    if (rst) begin
      search_en     <= 1'b0;
      search_key    <= '0;
      rd_en         <= 1'b0;
      rd_addr       <= '0;
      tag_q         <= '0;
      addr_q        <= '0;
      tmo           <= '0;
      lk.res_hit    <= 1'b0;
      lk.res_err    <= 1'b0;
      lk.res_addr   <= '0;
      lk.res_action <= '0;
      lk.res_tag    <= '0;
    end else begin
      search_en  <= (state_n == SRCH);
      search_key <= (state_n == SRCH) ? lk.key_data : '0;
      rd_en      <= (state_n == RD);
      rd_addr    <= (state_n == RD) ? match_addr : '0;
      tmo        <= (state == RWAIT) ? tmo + 1'b1 : '0;
      if (state == IDLE && lk.key_valid) tag_q <= lk.key_tag;
      if (state == MWAIT) addr_q <= match_addr;
      if (miss_inc) begin
        lk.res_hit    <= 1'b0;
        lk.res_err    <= 1'b0;
        lk.res_addr   <= '0;
        lk.res_action <= DEFAULT_ACTION;
        lk.res_tag    <= tag_q;
      end
      if (hit_inc) begin
        lk.res_hit    <= 1'b1;
        lk.res_err    <= !rd_valid;
        lk.res_addr   <= addr_q;
        lk.res_action <= rd_valid ? rd_data : DEFAULT_ACTION;
        lk.res_tag    <= tag_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || stats_clr) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (hit_inc && hit_cnt != '1)   hit_cnt  <= hit_cnt + 1'b1;
      if (miss_inc && miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_pmt_lookup_engine.sv
// Directed bench for pmt_lookup_engine with TCAM/SRAM models
// and a table-driven result/latency/counter predictor.
module tb_pmt_lookup_engine;
  localparam int AW  = 5;
  localparam int TMO = 8;
  localparam logic [31:0] DEF = 32'hD0D0F00D;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pmt_lookup_if #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .TAG_WIDTH(8)) lk();

  logic          search_en, rd_en;
  logic [31:0]   search_key;
  logic [AW-1:0] rd_addr;
  logic          match_found = 1'b0;
  logic [AW-1:0] match_addr = '0;
  logic [31:0]   rd_data = '0;
  logic          rd_valid = 1'b0;
  logic          stats_clr = 1'b0;
  logic [31:0]   hit_cnt, miss_cnt;

  pmt_lookup_engine #(
    .DATA_WIDTH(32), .ADDR_WIDTH(AW), .TAG_WIDTH(8),
    .DEFAULT_ACTION(DEF), .RD_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .lk(lk),
    .search_en(search_en), .search_key(search_key),
    .match_found(match_found), .match_addr(match_addr),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .stats_clr(stats_clr),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  logic [31:0] t_key [32];
  logic [31:0] t_mask[32];
  logic        t_vld [32];
  logic [31:0] sram  [32];
  logic        withhold = 1'b0;
  logic        stray = 1'b0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int lookup(input logic [31:0] k);
    for (int i = 0; i < 32; i++)
      if (t_vld[i] && ((k ^ t_key[i]) & t_mask[i]) == 32'h0)
        return i;
    return -1;
  endfunction

  // TCAM: registered, lowest index wins
  always @(posedge clk) begin
    int idx;
    idx = lookup(search_key);
    match_found <= (search_en && idx >= 0) || stray;
    match_addr  <= (search_en && idx >= 0) ? idx[AW-1:0] : '0;
  end

  always @(posedge clk) begin
    rd_valid <= (rd_en && !withhold) || stray;
    rd_data  <= sram[rd_addr];
  end

  typedef struct {
    logic          hit;
    logic          err;
    logic [AW-1:0] addr;
    logic [31:0]   act;
    logic [7:0]    tag;
    int            lat;
    int            acc;
  } exp_t;

  exp_t q[$];

  function automatic exp_t predict(input logic [31:0] k,
                                   input logic [7:0] t);
    exp_t e;
    int i;
    i = lookup(k);
    e.tag = t;
    e.acc = 0;
    if (i < 0) begin
      e.hit = 0; e.err = 0; e.addr = '0; e.act = DEF; e.lat = 3;
    end else if (withhold) begin
      e.hit = 1; e.err = 1; e.addr = i[AW-1:0]; e.act = DEF;
      e.lat = 4 + TMO;
    end else begin
      e.hit = 1; e.err = 0; e.addr = i[AW-1:0]; e.act = sram[i];
      e.lat = 5;
    end
    return e;
  endfunction

  int          n = 0;
  logic        rst_q = 1'b1;
  logic        clr_q = 1'b0;
  logic        rv_prev = 1'b0;
  logic [31:0] mh = '0;
  logic [31:0] mm = '0;

  always @(negedge clk) begin
    exp_t e;
    n++;
    if (rst_q) begin
      q.delete();
      mh = '0;
      mm = '0;
    end else begin
      if (clr_q) begin
        mh = '0;
        mm = '0;
      end
      if (lk.res_valid) begin
        if (q.size() == 0) chk("res_unexpected", 1, 0);
        else begin
          if (!rv_prev) begin
            chk("latency", n - q[0].acc, q[0].lat);
            if (!clr_q) begin
              if (q[0].hit) mh++;
              else          mm++;
            end
          end
          chk("res_hit", lk.res_hit, q[0].hit);
          chk("res_err", lk.res_err, q[0].err);
          chk("res_addr", lk.res_addr, q[0].addr);
          chk("res_action", lk.res_action, q[0].act);
          chk("res_tag", lk.res_tag, q[0].tag);
          if (lk.res_ready) void'(q.pop_front());
        end
      end
    end
    chk("hit_cnt", hit_cnt, mh);
    chk("miss_cnt", miss_cnt, mm);
    if (!rst && lk.key_valid && lk.key_ready) begin
      e = predict(lk.key_data, lk.key_tag);
      e.acc = n;
      q.push_back(e);
    end
    rst_q   = rst;
    clr_q   = stats_clr;
    rv_prev = lk.res_valid;
  end

  logic        se[16];
  logic [31:0] sk[16];
  logic        re[16];
  logic [4:0]  ra[16];

  task automatic send(input logic [31:0] k, input logic [7:0] t);
    int b;
    @(posedge clk); #1;
    lk.key_valid = 1'b1;
    lk.key_data  = k;
    lk.key_tag   = t;
    b = 0;
    @(negedge clk);
    while (!lk.key_ready && b < 60) begin
      @(negedge clk);
      b++;
    end
    if (!lk.key_ready) chk("accept_wait", 0, 1);
    @(posedge clk); #1;
    lk.key_valid = 1'b0;
  endtask

  task automatic wait_res(output int lat);
    lat = 0;
    for (int i = 0; i < 16; i++) begin
      se[i] = 0; sk[i] = '0; re[i] = 0; ra[i] = '0;
    end
    do begin
      @(negedge clk);
      lat++;
      if (lat < 16) begin
        se[lat] = search_en; sk[lat] = search_key;
        re[lat] = rd_en;     ra[lat] = rd_addr;
      end
    end while (!lk.res_valid && lat < 60);
    if (!lk.res_valid) chk("res_wait", 0, 1);
  endtask

  initial begin
    int lat;
    int b;
    for (int i = 0; i < 32; i++) begin
      t_key[i] = '0; t_mask[i] = '0; t_vld[i] = 0; sram[i] = 32'h1000 + i;
    end
    t_key[0] = 32'h0A000001; t_mask[0] = 32'hFFFFFFFF; t_vld[0] = 1;
    sram[0] = 32'hDEADBEEF;
    t_key[20] = 32'h0A000000; t_mask[20] = 32'hFF000000;
    t_key[21] = 32'h0A000000; t_mask[21] = 32'hFFFF0000;
    sram[20] = 32'hCAFEBABE;  sram[21] = 32'h12345678;
    lk.key_valid = 0; lk.key_data = '0; lk.key_tag = '0; lk.res_ready = 1;

    repeat (3) @(posedge clk); #1;
    @(negedge clk);
    chk("rst_key_ready", lk.key_ready, 0);
    chk("rst_res_valid", lk.res_valid, 0);
    chk("rst_search_en", search_en, 0);
    chk("rst_rd_en", rd_en, 0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("idle_key_ready", lk.key_ready, 1);

    send(32'h0A000001, 8'h3C);
    wait_res(lat);
    chk("t1_lat", lat, 5);
    chk("t1_se1", se[1], 1);
    chk("t1_sk1", sk[1], 32'h0A000001);
    chk("t1_se2", se[2], 0);
    chk("t1_sk2", sk[2], 0);
    chk("t1_re3", re[3], 1);
    chk("t1_re4", re[4], 0);
    chk("t1_hit", lk.res_hit, 1);
    chk("t1_addr", lk.res_addr, 0);
    chk("t1_action", lk.res_action, 32'hDEADBEEF);
    chk("t1_tag", lk.res_tag, 8'h3C);
    chk("t1_hit_cnt", hit_cnt, 1);

    send(32'h0A000003, 8'h55);
    wait_res(lat);
    chk("t2_lat", lat, 3);
    chk("t2_hit", lk.res_hit, 0);
    chk("t2_addr", lk.res_addr, 0);
    chk("t2_action", lk.res_action, DEF);
    chk("t2_re", re[3], 0);
    @(negedge clk);
    chk("t2_miss_cnt", miss_cnt, 1);

    @(posedge clk); #1;
    t_vld[20] = 1; t_vld[21] = 1;
    send(32'h0A001234, 8'h77);
    wait_res(lat);
    chk("t3_lat", lat, 5);
    chk("t3_rd_addr", ra[3], 20);
    chk("t3_addr", lk.res_addr, 20);
    chk("t3_action", lk.res_action, 32'hCAFEBABE);

    @(posedge clk); #1 stray = 1;
    @(posedge clk); #1 stray = 0;
    repeat (3) begin
      @(negedge clk);
      chk("stray_res_valid", lk.res_valid, 0);
      chk("stray_key_ready", lk.key_ready, 1);
    end

    @(posedge clk); #1 lk.res_ready = 0;
    send(32'h0A000001, 8'h11);
    wait_res(lat);
    chk("hold_lat", lat, 5);
    @(posedge clk); #1;
    lk.key_valid = 1; lk.key_data = 32'h0B000003; lk.key_tag = 8'h22;
    repeat (6) begin
      @(negedge clk);
      chk("hold_res_valid", lk.res_valid, 1);
      chk("hold_key_ready", lk.key_ready, 0);
      chk("hold_tag", lk.res_tag, 8'h11);
      chk("hold_action", lk.res_action, 32'hDEADBEEF);
    end
    @(posedge clk); #1 lk.res_ready = 1;
    b = 0;
    @(negedge clk);
    while (!lk.key_ready && b < 20) begin
      @(negedge clk);
      b++;
    end
    chk("hold_release", lk.key_ready, 1);
    @(posedge clk); #1 lk.key_valid = 0;
    wait_res(lat);
    chk("next_lat", lat, 3);
    chk("next_tag", lk.res_tag, 8'h22);
    chk("next_hit", lk.res_hit, 0);

    withhold = 1;
    send(32'h0A000001, 8'h44);
    wait_res(lat);
    chk("tmo_lat", lat, 4 + TMO);
    chk("tmo_hit", lk.res_hit, 1);
    chk("tmo_err", lk.res_err, 1);
    chk("tmo_action", lk.res_action, DEF);
    chk("tmo_hit_cnt", hit_cnt, 4);
    chk("tmo_miss_cnt", miss_cnt, 2);
    @(posedge clk); #1 withhold = 0;

    send(32'h0A000001, 8'h66);
    repeat (3) @(posedge clk);
    #1 stats_clr = 1;
    @(posedge clk); #1 stats_clr = 0;
    @(negedge clk);
    chk("clr_res_valid", lk.res_valid, 1);
    chk("clr_hit_cnt", hit_cnt, 0);
    chk("clr_miss_cnt", miss_cnt, 0);
    send(32'h0B000003, 8'h01);
    wait_res(lat);
    chk("clr_then_miss", miss_cnt, 1);

    @(posedge clk); #1 withhold = 1;
    send(32'h0A001234, 8'h99);
    repeat (5) @(negedge clk);
    @(posedge clk); #1 rst = 1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_res_valid", lk.res_valid, 0);
    chk("mid_rst_key_ready", lk.key_ready, 0);
    chk("mid_rst_hit_cnt", hit_cnt, 0);
    chk("mid_rst_miss_cnt", miss_cnt, 0);
    chk("mid_rst_rd_en", rd_en, 0);
    @(posedge clk); #1;
    rst = 0;
    withhold = 0;
    repeat (12) begin
      @(negedge clk);
      chk("post_rst_idle", lk.res_valid, 0);
    end
    send(32'h0A000001, 8'h5A);
    wait_res(lat);
    chk("post_rst_lat", lat, 5);
    chk("post_rst_action", lk.res_action, 32'hDEADBEEF);
    chk("post_rst_hit_cnt", hit_cnt, 1);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
